// File: rtl/esteira_posicionador.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : esteira_posicionador
// Brief    : Timed conveyor position model; converts motor command into
//            station-arrival flags and counts completed bottle loops.
// Revision : 1.0 - initial release
// ============================================================================
module esteira_posicionador #(
    parameter int CICLOS_TRECHO = 50000000,
    parameter int LARGURA_TIMER = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       motor_ativo,
    output logic       posicao_enchimento,
    output logic       posicao_vedacao,
    output logic       posicao_cq,
    output logic       posicao_final,
    output logic       chegada,
    output logic       em_transito,
    output logic [1:0] estacao_atual,
    output logic [7:0] ciclos_completos
);

    localparam logic [LARGURA_TIMER-1:0] C_TIMER_FIM = LARGURA_TIMER'(CICLOS_TRECHO - 1);
    localparam logic [LARGURA_TIMER-1:0] C_TIMER_UM  = LARGURA_TIMER'(1);

    typedef enum logic [0:0] {
        PARADO   = 1'b0,
        TRANSITO = 1'b1
    } estado_t;

    estado_t                  r_estado_q,   w_estado_d;
    logic [LARGURA_TIMER-1:0] r_timer_q,    w_timer_d;
    logic [1:0]               r_estacao_q,  w_estacao_d;
    logic [7:0]               r_ciclos_q,   w_ciclos_d;
    logic [3:0]               r_posicao_q,  w_posicao_d;
    logic                     r_chegada_q,  w_chegada_d;
    logic                     r_transito_q, w_transito_d;

    always_comb begin
        w_estado_d  = r_estado_q;
        w_timer_d   = r_timer_q;
        w_estacao_d = r_estacao_q;
        w_ciclos_d  = r_ciclos_q;
        w_chegada_d = 1'b0;

        case (r_estado_q)
            PARADO: begin
                if (motor_ativo) begin
                    w_estado_d = TRANSITO;
                    w_timer_d  = '0;
                end
            end
            TRANSITO: begin
                // With the motor off the timer simply holds: bottle stalls mid-segment.
                if (motor_ativo) begin
                    if (r_timer_q == C_TIMER_FIM) begin
                        w_estado_d  = PARADO;
                        w_timer_d   = '0;
                        w_estacao_d = r_estacao_q + 2'd1;
                        w_chegada_d = 1'b1;
                        if (r_estacao_q == 2'd3) begin
                            w_ciclos_d = r_ciclos_q + 8'd1;
                        end
                    end else begin
                        w_timer_d = r_timer_q + C_TIMER_UM;
                    end
                end
            end
            default: begin
                w_estado_d = PARADO;
            end
        endcase

        // Outputs are precomputed from the next state so they come straight off flops.
        w_transito_d = (w_estado_d == TRANSITO);
        w_posicao_d  = (w_estado_d == PARADO) ? (4'b0001 << w_estacao_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_estado_q   <= PARADO;
            r_timer_q    <= '0;
            r_estacao_q  <= 2'd0;
            r_ciclos_q   <= 8'd0;
            r_posicao_q  <= 4'b0001;
            r_chegada_q  <= 1'b0;
            r_transito_q <= 1'b0;
        end else begin
            r_estado_q   <= w_estado_d;
            r_timer_q    <= w_timer_d;
            r_estacao_q  <= w_estacao_d;
            r_ciclos_q   <= w_ciclos_d;
            r_posicao_q  <= w_posicao_d;
            r_chegada_q  <= w_chegada_d;
            r_transito_q <= w_transito_d;
        end
    end

    assign posicao_enchimento = r_posicao_q[0];
    assign posicao_vedacao    = r_posicao_q[1];
    assign posicao_cq         = r_posicao_q[2];
    assign posicao_final      = r_posicao_q[3];
    assign chegada            = r_chegada_q;
    assign em_transito        = r_transito_q;
    assign estacao_atual      = r_estacao_q;
    assign ciclos_completos   = r_ciclos_q;

endmodule
`default_nettype wire

// File: tb/tb_esteira_posicionador.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_esteira_posicionador
// Brief    : Self-checking bench: fixed vector table, corner sequences and a
//            randomized run against a segment-progress reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_esteira_posicionador;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motor_ativo = 1'b0;
    logic       posicao_enchimento, posicao_vedacao, posicao_cq, posicao_final;
    logic       chegada, em_transito;
    logic [1:0] estacao_atual;
    logic [7:0] ciclos_completos;

    esteira_posicionador #(
        .CICLOS_TRECHO(C),
        .LARGURA_TIMER(3)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .motor_ativo       (motor_ativo),
        .posicao_enchimento(posicao_enchimento),
        .posicao_vedacao   (posicao_vedacao),
        .posicao_cq        (posicao_cq),
        .posicao_final     (posicao_final),
        .chegada           (chegada),
        .em_transito       (em_transito),
        .estacao_atual     (estacao_atual),
        .ciclos_completos  (ciclos_completos)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int arrivals    = 0;

    // Reference: a bottle is either parked at a station or has accrued some
    // number of active-motor cycles towards the next one.
    int m_station  = 0;
    bit m_moving   = 1'b0;
    int m_progress = 0;
    int m_loops    = 0;
    bit m_arrived  = 1'b0;

    typedef struct {
        logic       rst;
        logic       mot;
        logic [3:0] pos;
        logic       em;
        logic       ch;
        logic [1:0] est;
        logic [7:0] cc;
    } vec_t;

    vec_t tabela[9];

    function automatic logic [3:0] dut_pos();
        return {posicao_final, posicao_cq, posicao_vedacao, posicao_enchimento};
    endfunction

    task automatic model_update(input logic rv, input logic mv);
        if (rv) begin
            m_station = 0; m_moving = 1'b0; m_progress = 0; m_loops = 0; m_arrived = 1'b0;
        end else begin
            m_arrived = 1'b0;
            if (!m_moving) begin
                if (mv) begin
                    m_moving   = 1'b1;
                    m_progress = 0;
                end
            end else if (mv) begin
                m_progress++;
                if (m_progress == C) begin
                    m_moving  = 1'b0;
                    m_arrived = 1'b1;
                    if (m_station == 3) m_loops = (m_loops + 1) % 256;
                    m_station = (m_station + 1) % 4;
                end
            end
        end
    endtask

    task automatic compare(input string name, input logic [3:0] pos, input logic em,
                           input logic ch, input logic [1:0] est, input logic [7:0] cc);
        vectors++;
        if (dut_pos() !== pos || em_transito !== em || chegada !== ch ||
            estacao_atual !== est || ciclos_completos !== cc) begin
            miscompares++;
            $display("FAIL %s t=%0t: got pos=%b em=%b ch=%b est=%0d cc=%0d, expected pos=%b em=%b ch=%b est=%0d cc=%0d",
                     name, $time, dut_pos(), em_transito, chegada, estacao_atual, ciclos_completos,
                     pos, em, ch, est, cc);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic rv, input logic mv);
        logic [3:0] epos;
        reset       = rv;
        motor_ativo = mv;
        @(posedge clk);
        model_update(rv, mv);
        #1;
        epos = m_moving ? 4'b0000 : (4'b0001 << m_station);
        compare("model", epos, m_moving, m_arrived, 2'(m_station), 8'(m_loops));
        if (chegada === 1'b1) arrivals++;
    endtask

    // Motor held high from a parked position; n = cycles until chegada, -1 on timeout.
    task automatic run_segment(output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1);
            n++;
            if (chegada === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) n = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tabela[0] = '{1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd0};
        tabela[1] = '{1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 8'd0};
        tabela[2] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0};
        tabela[3] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0};
        tabela[4] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0};
        tabela[5] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 8'd0};
        tabela[6] = '{1'b0, 1'b1, 4'b0010, 1'b0, 1'b1, 2'd1, 8'd0};
        tabela[7] = '{1'b0, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd1, 8'd0};
        tabela[8] = '{1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd1, 8'd0};

        #2;
        for (int i = 0; i < 9; i++) begin
            step(tabela[i].rst, tabela[i].mot);
            compare($sformatf("table[%0d]", i), tabela[i].pos, tabela[i].em,
                    tabela[i].ch, tabela[i].est, tabela[i].cc);
        end

        // Mid-segment stall: 1 rise + 2 active + 10 stalled, then resume.
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (10) step(1'b0, 1'b0);
        run_segment(n);
        check_val("stall total cycles", (n < 0) ? -1 : n + 13, 15);
        check_val("stall station", int'(estacao_atual), 1);
        step(1'b0, 1'b0);
        check_val("stall parked vedacao", int'(posicao_vedacao), 1);

        // Full loop with a 3-cycle dwell at each station.
        step(1'b1, 1'b0);
        arrivals = 0;
        for (int s = 0; s < 4; s++) begin
            run_segment(n);
            check_val($sformatf("loop seg%0d cycles", s), n, C + 1);
            check_val($sformatf("loop seg%0d station", s), int'(estacao_atual), (s + 1) % 4);
            repeat (3) step(1'b0, 1'b0);
        end
        check_val("loop arrivals", arrivals, 4);
        check_val("loop ciclos", int'(ciclos_completos), 1);

        // Reset on the arrival edge: reset values only, no pulse, counter cleared.
        step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        compare("reset at arrival", 4'b0001, 1'b0, 1'b0, 2'd0, 8'd0);

        // Reset mid-transit at timer=2, then a fresh full segment is needed.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        compare("reset mid transit", 4'b0001, 1'b0, 1'b0, 2'd0, 8'd0);
        run_segment(n);
        check_val("post-reset segment cycles", n, C + 1);

        // Counter wrap after 256 full loops.
        step(1'b1, 1'b0);
        for (int l = 0; l < 256; l++) begin
            for (int s = 0; s < 4; s++) begin
                run_segment(n);
                if (n != C + 1) check_val("wrap segment cycles", n, C + 1);
                step(1'b0, 1'b0);
            end
            if (l == 254) check_val("ciclos at 255", int'(ciclos_completos), 255);
        end
        check_val("ciclos wrapped", int'(ciclos_completos), 0);
        check_val("wrap enchimento", int'(posicao_enchimento), 1);

        // Randomized run against the reference model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/esteira_posicionador.md
# esteira_posicionador

Conveyor position model for the bottling line. It turns the motor command into discrete station-arrival signals: filling, sealing, quality control (CQ) and final. It sits directly upstream of the main process FSM and replaces the manual position switches with timed, deterministic position sensors. It also counts completed bottle cycles for the display path.

## Interface
Parameters:
- CICLOS_TRECHO, default 50000000: active-motor clock cycles needed to travel one segment (1 s at 50 MHz). Must be ≥ 1.
- LARGURA_TIMER, default 26: width of the segment timer. Must hold CICLOS_TRECHO-1.

Ports:
- clk  in  1  system clock, CLOCK_50 domain
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- motor_ativo  in  1  conveyor motor command from the main FSM
- posicao_enchimento  out  1  bottle parked at filling station
- posicao_vedacao  out  1  bottle parked at sealing station
- posicao_cq  out  1  bottle parked at CQ station
- posicao_final  out  1  bottle parked at final/output station
- chegada  out  1  one-cycle pulse on any station arrival
- em_transito  out  1  conveyor between stations
- estacao_atual  out  2  current or last station: 0=enchimento, 1=vedacao, 2=cq, 3=final
- ciclos_completos  out  8  count of FINAL→ENCHIMENTO transitions; wraps modulo 256

## Operation
- State machine has two states: PARADO and TRANSITO. A 2-bit station register, a LARGURA_TIMER-bit timer and an 8-bit cycle counter sit alongside it.
- Reset (synchronous, highest priority) sets:
  - state=PARADO, estacao_atual=0, timer=0, ciclos_completos=0
  - posicao_enchimento=1; every other posicao_* =0
  - chegada=0, em_transito=0
- PARADO:
  - posicao_* is one-hot decode of estacao_atual.
  - em_transito=0.
  - If motor_ativo=1, go to TRANSITO with timer=0.
- TRANSITO:
  - All posicao_* =0; em_transito=1.
  - motor_ativo=1 and timer<CICLOS_TRECHO-1: timer+1.
  - motor_ativo=1 and timer==CICLOS_TRECHO-1: arrival.
    - estacao_atual ← (estacao_atual+1) mod 4
    - state ← PARADO, timer ← 0, chegada=1 for one cycle
  - motor_ativo=0: timer holds and state stays TRANSITO. The conveyor is stopped mid-segment; no position is asserted. Travel resumes from the held count when motor_ativo returns.
- Wrap from station 3 to station 0 increments ciclos_completos in the arrival cycle; 255 wraps to 0.
- If motor_ativo is still 1 in the arrival cycle's successor, the next segment starts immediately. The posicao_* for the new station is then high for exactly one cycle. The master must deassert motor_ativo on chegada to dwell at a station.
- estacao_atual in TRANSITO shows the station just left.
- Outputs are registered; no combinational path from motor_ativo to any output.

## Timing
- motor_ativo rises in PARADO at edge t: em_transito=1 and posicao_*=0 from t+1.
- With motor held high, arrival registers at edge t+CICLOS_TRECHO. chegada, the new posicao_* and the updated estacao_atual are all visible in the same cycle.
- Total latency from motor command to position is CICLOS_TRECHO+1 clocks, plus the number of cycles motor_ativo was low during transit.
- chegada is never high for two consecutive cycles. When CICLOS_TRECHO=1 with continuous motor, it is high at most every other cycle.
- Reset asserted mid-transit wins on that edge. The next cycle shows station 0 parked and the timer cleared; ciclos_completos clears as well.
- Reset coinciding with an arrival edge: reset values only; no chegada pulse, no count increment.

## Test plan
Benches use CICLOS_TRECHO=4.
- Reset check: hold reset 2 cycles -> posicao_enchimento=1, estacao_atual=0, em_transito=0, chegada=0, ciclos_completos=0.
- Single segment: motor_ativo=1 for 1 cycle, then 1 continuously until chegada, then 0 -> em_transito high 4 cycles; chegada pulses once; posicao_vedacao=1; estacao_atual=1.
- Mid-segment stall: motor high 2 transit cycles, low 10, high again -> positions stay 0 while stalled; arrival only after 2 more active cycles; total 15 cycles from motor rise.
- Full loop: drive 4 segments with a 3-cycle dwell each -> stations visited in order 1,2,3,0; ciclos_completos=1; exactly 4 chegada pulses.
- Counter wrap: 256 full loops -> ciclos_completos returns to 0; posicao_enchimento=1 at end.
- Reset mid-transit: assert reset while timer=2 -> next cycle PARADO at station 0; a fresh 4-cycle segment is required for the next arrival.
